vga_pattern_gen: RTL and testbench



---
 rtl/vga_pattern_gen.sv | 235 +++++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// vga_pattern_gen
//
// Pixel source that sits directly after the VGA timing generator. It turns
// the generator's registered sync/position/de stream into 4:4:4 RGB test
// patterns and delays the sync/de signals by the same two cycles, so every
// output reaches the pin stage on the same clock.
//
// Patterns (selected once per frame from mode):
//   0 colour bars, 1 checkerboard, 2 gradient, 3 animated bouncing box.
//
// Ports:
//   clk        in   pixel clock, rising edge
//   rst        in   synchronous active-high reset
//   hsync_in   in   hsync from timing generator (output polarity)
//   vsync_in   in   vsync from timing generator (output polarity)
//   x_in[10:0] in   pixel column
//   y_in[10:0] in   line number
//   de_in      in   active-video flag
//   mode[1:0]  in   pattern select, sampled at frame start
//   freeze     in   hold frame counter and box animation
//   hsync_out  out  hsync_in delayed 2 cycles
//   vsync_out  out  vsync_in delayed 2 cycles
//   de_out     out  de_in delayed 2 cycles
//   r,g,b[3:0] out  pixel colour, aligned with de_out, zero when blanked
//   frame_cnt  out  frames since reset, wraps at 255
// ---------------------------------------------------------------------------
module vga_pattern_gen #(
  parameter int ACTIVE_WIDTH  = 640,
  parameter int ACTIVE_HEIGHT = 480,
  parameter int BOX_SIZE      = 32,
  parameter int STEP          = 2,
  parameter int CHECK_SHIFT   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [10:0] x_in,
  input  logic [10:0] y_in,
  input  logic        de_in,
  input  logic [1:0]  mode,
  input  logic        freeze,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic [7:0]  frame_cnt
);

  // Position arithmetic is 11 bits; comparisons run at 12 bits so that
  // pos + BOX_SIZE + STEP can never wrap.
  localparam logic [11:0] W12    = 12'(ACTIVE_WIDTH);
  localparam logic [11:0] H12    = 12'(ACTIVE_HEIGHT);
  localparam logic [11:0] BOX12  = 12'(BOX_SIZE);
  localparam logic [11:0] STEP12 = 12'(STEP);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam int          BAR_W  = ACTIVE_WIDTH / 8;

  localparam logic [11:0] C_BOX_IN  = 12'hF80;
  localparam logic [11:0] C_BOX_OUT = 12'h002;

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // One axis of the bouncing box. Returns {dir_fwd_next, pos_next}.
  // A bounce only flips direction; the position holds for that frame.
  function automatic logic [11:0] f_axis_next(input logic [10:0] pos,
                                              input logic        dir_fwd,
                                              input logic [11:0] limit);
    logic [11:0] w_pos12;
    w_pos12 = {1'b0, pos};
    if (dir_fwd) begin
      if (w_pos12 + BOX12 + STEP12 > limit) return {1'b0, pos};
      else                                  return {1'b1, pos + STEP11};
    end else begin
      if (w_pos12 < STEP12) return {1'b1, pos};
      else                  return {1'b0, pos - STEP11};
    end
  endfunction

  // Bar index from a ladder of threshold compares; avoids a divider.
  function automatic logic [2:0] f_bar_idx(input logic [10:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, x} >= 12'(k * BAR_W)) idx = 3'(k);
    end
    return idx;
  endfunction

  function automatic logic [11:0] f_bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 12'hFFF;
      3'd1:    return 12'hFF0;
      3'd2:    return 12'h0FF;
      3'd3:    return 12'h0F0;
      3'd4:    return 12'hF0F;
      3'd5:    return 12'hF00;
      3'd6:    return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic f_in_span(input logic [10:0] p, input logic [10:0] lo);
    return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < ({1'b0, lo} + BOX12));
  endfunction

  // -------------------------------------------------------------------------
  // Frame-level state: frame start detect, mode latch, counter, box
  // -------------------------------------------------------------------------
  logic        r_origin_q;
  logic [1:0]  r_mode_q;
  logic [10:0] r_bx;
  logic [10:0] r_by;
  logic        r_dir_x;   // 1 = right
  logic        r_dir_y;   // 1 = down
  logic [7:0]  r_frame_cnt;

  logic        w_at_origin;
  logic        w_frame_start;
  logic [11:0] w_nx;
  logic [11:0] w_ny;

  // Qualifying with the previous cycle stops a stalled upstream (sitting at
  // 0,0) from generating a frame start every clock.
  assign w_at_origin   = (x_in == 11'd0) && (y_in == 11'd0);
  assign w_frame_start = w_at_origin && !r_origin_q;

  assign w_nx = f_axis_next(r_bx, r_dir_x, W12);
  assign w_ny = f_axis_next(r_by, r_dir_y, H12);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_origin_q  <= 1'b0;
      r_mode_q    <= 2'd0;
      r_bx        <= 11'd0;
      r_by        <= 11'd0;
      r_dir_x     <= 1'b1;
      r_dir_y     <= 1'b1;
      r_frame_cnt <= 8'd0;
    end else begin
      r_origin_q <= w_at_origin;
      if (w_frame_start) begin
        r_mode_q <= mode;
        if (!freeze) begin
          r_frame_cnt <= r_frame_cnt + 8'd1;
          r_bx        <= w_nx[10:0];
          r_dir_x     <= w_nx[11];
          r_by        <= w_ny[10:0];
          r_dir_y     <= w_ny[11];
        end
      end
    end
  end

  assign frame_cnt = r_frame_cnt;

  // -------------------------------------------------------------------------
  // Stage 1: register timing inputs
  // -------------------------------------------------------------------------
  // The frame-level state updates on the same edge that loads the origin
  // pixel here, so the decode below always sees the new frame's mode, box
  // and counter from its very first pixel.
  logic        r_hsync_p1;
  logic        r_vsync_p1;
  logic        r_de_p1;
  logic [10:0] r_x_p1;
  logic [10:0] r_y_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync_p1 <= 1'b0;
      r_vsync_p1 <= 1'b0;
      r_de_p1    <= 1'b0;
      r_x_p1     <= 11'd0;
      r_y_p1     <= 11'd0;
    end else begin
      r_hsync_p1 <= hsync_in;
      r_vsync_p1 <= vsync_in;
      r_de_p1    <= de_in;
      r_x_p1     <= x_in;
      r_y_p1     <= y_in;
    end
  end

  // Pattern decode on the stage-1 pixel
  logic [11:0] w_rgb_p1;

  always_comb begin
    w_rgb_p1 = 12'h000;
    case (r_mode_q)
      2'd0: w_rgb_p1 = f_bar_colour(f_bar_idx(r_x_p1));
      2'd1: w_rgb_p1 = (r_x_p1[CHECK_SHIFT] ^ r_y_p1[CHECK_SHIFT]) ? 12'hFFF : 12'h000;
      2'd2: w_rgb_p1 = {r_x_p1[9:6], r_y_p1[8:5], r_frame_cnt[7:4]};
      default: begin
        if (f_in_span(r_x_p1, r_bx) && f_in_span(r_y_p1, r_by)) w_rgb_p1 = C_BOX_IN;
        else                                                    w_rgb_p1 = C_BOX_OUT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage 2: output registers, colour forced to black outside active video
  // -------------------------------------------------------------------------
  logic        r_hsync_p2;
  logic        r_vsync_p2;
  logic        r_de_p2;
  logic [11:0] r_rgb_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hsync_p2 <= 1'b0;
      r_vsync_p2 <= 1'b0;
      r_de_p2    <= 1'b0;
      r_rgb_p2   <= 12'h000;
    end else begin
      r_hsync_p2 <= r_hsync_p1;
      r_vsync_p2 <= r_vsync_p1;
      r_de_p2    <= r_de_p1;
      r_rgb_p2   <= r_de_p1 ? w_rgb_p1 : 12'h000;
    end
  end

  assign hsync_out = r_hsync_p2;
  assign vsync_out = r_vsync_p2;
  assign de_out    = r_de_p2;
  assign r         = r_rgb_p2[11:8];
  assign g         = r_rgb_p2[7:4];
  assign b         = r_rgb_p2[3:0];

endmodule

// File: tb/tb_vga_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_pattern_gen
//
// Directed bench for vga_pattern_gen. Frames are abbreviated: a frame is an
// origin pixel followed by whichever probe pixels a check needs, each probe
// followed by one blanking filler so its colour can be read two edges later.
// ---------------------------------------------------------------------------
module tb_vga_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync_in, vsync_in, de_in, freeze;
  logic [10:0] x_in, y_in;
  logic [1:0]  mode;
  logic        hsync_out, vsync_out, de_out;
  logic [3:0]  r, g, b;
  logic [7:0]  frame_cnt;
  logic [11:0] rgb_o;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  assign rgb_o = {r, g, b};

  vga_pattern_gen dut (
    .clk       (clk),
    .rst       (rst),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .x_in      (x_in),
    .y_in      (y_in),
    .de_in     (de_in),
    .mode      (mode),
    .freeze    (freeze),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out),
    .de_out    (de_out),
    .r         (r),
    .g         (g),
    .b         (b),
    .frame_cnt (frame_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of upstream timing at the falling edge, then sample
  // just after the following rising edge.
  task automatic tick(input logic hs, input logic vs, input logic de,
                      input logic [10:0] x, input logic [10:0] y);
    @(negedge clk);
    hsync_in = hs;
    vsync_in = vs;
    de_in    = de;
    x_in     = x;
    y_in     = y;
    @(posedge clk);
    #1;
  endtask

  task automatic px(input string tag, input logic [10:0] x, input logic [10:0] y,
                    input logic de, input logic [11:0] exp);
    tick(1'b0, 1'b0, de, x, y);
    tick(1'b0, 1'b0, 1'b0, 11'd1000, 11'd1000);
    check_val(tag, 32'(rgb_o), 32'(exp));
    check_val({tag, "_de"}, 32'(de_out), 32'(de));
  endtask

  // Expected box corner after n un-frozen frame starts from reset (640x480,
  // box 32, step 2): right edge reached at n=304 (608), bounce frame 305.
  function automatic int exp_bx(input int n);
    if (n <= 304)      return 2 * n;
    else if (n == 305) return 608;
    else               return 608 - 2 * (n - 305);
  endfunction

  // Bottom edge reached at n=224 (448), bounce frame 225.
  function automatic int exp_by(input int n);
    if (n <= 224)      return 2 * n;
    else if (n == 225) return 448;
    else               return 448 - 2 * (n - 225);
  endfunction

  task automatic box_frame(input int n, input int bx, input int by);
    px($sformatf("f%0d_org", n), 11'd0, 11'd0, 1'b1, 12'h002);
    px($sformatf("f%0d_tl", n), 11'(bx), 11'(by), 1'b1, 12'hF80);
    px($sformatf("f%0d_br", n), 11'(bx + 31), 11'(by + 31), 1'b1, 12'hF80);
    px($sformatf("f%0d_rt", n), 11'(bx + 32), 11'(by), 1'b1, 12'h002);
    px($sformatf("f%0d_lf", n), 11'(bx - 1), 11'(by), 1'b1, 12'h002);
    px($sformatf("f%0d_bt", n), 11'(bx), 11'(by + 32), 1'b1, 12'h002);
    px($sformatf("f%0d_up", n), 11'(bx), 11'(by - 1), 1'b1, 12'h002);
  endtask

  initial begin
    logic p_hs, p_vs, p_de;
    logic c_hs, c_vs, c_de;

    rst = 1'b1; mode = 2'd0; freeze = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; de_in = 1'b0; x_in = 11'd0; y_in = 11'd0;

    // Reset state, with busy inputs
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 11'd5, 11'd5);
    check_val("rst_hs", 32'(hsync_out), 32'd0);
    check_val("rst_vs", 32'(vsync_out), 32'd0);
    check_val("rst_de", 32'(de_out), 32'd0);
    check_val("rst_rgb", 32'(rgb_o), 32'd0);
    check_val("rst_fc", 32'(frame_cnt), 32'd0);
    rst = 1'b0;

    // Miniature timing sequence: 2 frames of 4 lines x 20 clocks.
    p_hs = 1'b0; p_vs = 1'b0; p_de = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int yy = 0; yy < 4; yy++) begin
        for (int h = 0; h < 20; h++) begin
          c_hs = (h >= 14) && (h < 17);
          c_vs = (yy == 3);
          c_de = (h < 12) && (yy < 3);
          tick(c_hs, c_vs, c_de, 11'(h), 11'(yy));
          check_val("dly_hs", 32'(hsync_out), 32'(p_hs));
          check_val("dly_vs", 32'(vsync_out), 32'(p_vs));
          check_val("dly_de", 32'(de_out), 32'(p_de));
          check_val("dly_rgb", 32'(rgb_o), p_de ? 32'h0FFF : 32'h0);
          if (h == 0 && yy == 0) check_val("fc_origin", 32'(frame_cnt), 32'(f + 1));
          p_hs = c_hs; p_vs = c_vs; p_de = c_de;
        end
      end
    end

    // Colour bars (frame 3)
    px("bar_org", 11'd0, 11'd0, 1'b1, 12'hFFF);
    check_val("fc3", 32'(frame_cnt), 32'd3);
    px("bar_0", 11'd0, 11'd10, 1'b1, 12'hFFF);
    px("bar_79", 11'd79, 11'd10, 1'b1, 12'hFFF);
    px("bar_80", 11'd80, 11'd10, 1'b1, 12'hFF0);
    px("bar_320", 11'd320, 11'd10, 1'b1, 12'hF0F);
    px("bar_400", 11'd400, 11'd10, 1'b1, 12'hF00);
    px("bar_639", 11'd639, 11'd10, 1'b1, 12'h000);
    px("bar_blank", 11'd100, 11'd10, 1'b0, 12'h000);

    // Checker (frame 4) and gradient (frame 5)
    mode = 2'd1;
    px("chk_org", 11'd0, 11'd0, 1'b1, 12'h000);
    px("chk_32_0", 11'd32, 11'd0, 1'b1, 12'hFFF);
    px("chk_32_32", 11'd32, 11'd32, 1'b1, 12'h000);
    mode = 2'd2;
    px("grd_org", 11'd0, 11'd0, 1'b1, 12'h000);
    px("grd_639", 11'd639, 11'd479, 1'b1, 12'h9E0);

    // Bouncing box from a fresh reset, 310 frames
    rst = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 11'd1000, 11'd1000);
    check_val("rst2_fc", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    mode = 2'd3;
    for (int n = 1; n <= 310; n++) box_frame(n, exp_bx(n), exp_by(n));
    check_val("fc310", 32'(frame_cnt), 32'd54);

    // Gradient blue from a wrapped counter: frame 311 -> 55 = 0x37
    mode = 2'd2;
    px("grd2_org", 11'd0, 11'd0, 1'b1, 12'h003);
    px("grd2_639", 11'd639, 11'd479, 1'b1, 12'h9E3);
    check_val("fc311", 32'(frame_cnt), 32'd55);

    // Upstream held at origin: exactly one frame start (frame 312)
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b0, 1'b0, 11'd0, 11'd0);
    tick(1'b0, 1'b0, 1'b0, 11'd1000, 11'd1000);
    check_val("fc_hold", 32'(frame_cnt), 32'd56);

    // Freeze across 3 frames: counter and box stay at frame-312 state
    mode = 2'd3; freeze = 1'b1;
    for (int k = 0; k < 3; k++) begin
      box_frame(312, exp_bx(312), exp_by(312));
      check_val("fc_frz", 32'(frame_cnt), 32'd56);
    end

    // Mid-frame mode change takes effect only at the next origin
    freeze = 1'b0; mode = 2'd0;
    px("mc_org", 11'd0, 11'd0, 1'b1, 12'hFFF);
    check_val("fc57", 32'(frame_cnt), 32'd57);
    px("mc_bar80", 11'd80, 11'd200, 1'b1, 12'hFF0);
    mode = 2'd1;
    px("mc_keep80", 11'd80, 11'd200, 1'b1, 12'hFF0);
    px("mc_keep0", 11'd0, 11'd200, 1'b1, 12'hFFF);
    px("mc_new_org", 11'd0, 11'd0, 1'b1, 12'h000);
    px("mc_new80", 11'd80, 11'd200, 1'b1, 12'h000);

    // Reset in the middle of an active line
    tick(1'b1, 1'b1, 1'b1, 11'd100, 11'd250);
    tick(1'b1, 1'b1, 1'b1, 11'd101, 11'd250);
    check_val("pre_rst_de", 32'(de_out), 32'd1);
    rst = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 11'd100, 11'd250);
    check_val("mr_hs", 32'(hsync_out), 32'd0);
    check_val("mr_vs", 32'(vsync_out), 32'd0);
    check_val("mr_de", 32'(de_out), 32'd0);
    check_val("mr_rgb", 32'(rgb_o), 32'd0);
    check_val("mr_fc", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    tick(1'b1, 1'b1, 1'b1, 11'd100, 11'd250);
    check_val("post_rst_de", 32'(de_out), 32'd0);
    check_val("post_rst_rgb", 32'(rgb_o), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 11'd1000, 11'd250);
    check_val("refill_hs", 32'(hsync_out), 32'd1);
    check_val("refill_de", 32'(de_out), 32'd1);
    check_val("refill_rgb", 32'(rgb_o), 32'h0FF0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
